hp_manager: RTL and testbench

- Owns the player's HP state and produces the `i_total_hp` / `i_remain_hp` pair consumed by the HP-bar geometry block.
- Accepts damage/heal requests from the battle logic over a valid/ready handshake.
- Runs post-hit invulnerability counted in video frames.
- Animates the displayed HP draining toward the true HP.
- Flags death once the drain animation reaches zero.

---
 rtl/hp_manager.sv | 149 ++++++++++++++
 tb/tb_hp_manager.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_manager.sv
// ============================================================================
// hp_manager : player HP state, damage/heal handshake, frame-counted
//              post-hit invulnerability, and animated display-HP drain.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hp_manager #(
  parameter int MAX_HP    = 20,
  parameter int INV_TICKS = 60,
  parameter int DRAIN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_restart,
  input  logic        i_frame_tick,
  input  logic        i_req_valid,
  input  logic        i_req_heal,
  input  logic [15:0] i_req_amt,
  output logic        o_req_ready,
  output logic [15:0] o_total_hp,
  output logic [15:0] o_remain_hp,
  output logic [15:0] o_actual_hp,
  output logic        o_invuln,
  output logic        o_hit_pulse,
  output logic        o_dead
);

  localparam int          INV_W = (INV_TICKS > 1) ? $clog2(INV_TICKS + 1) : 1;
  localparam int          PRE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [15:0] C_MAX_HP   = 16'(MAX_HP);
  localparam logic [INV_W-1:0] C_INV_LOAD = INV_W'(INV_TICKS);
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(DRAIN_DIV - 1);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      actual_q, actual_d;
  logic [15:0]      remain_q, remain_d;
  logic [INV_W-1:0] inv_q, inv_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             hit_q, hit_d;
  logic             dead_q, dead_d;

  logic        w_accept;
  logic        w_strobe;
  logic [16:0] w_heal_sum;
  logic [15:0] w_heal_hp;
  logic [15:0] w_dmg_hp;

  assign w_accept   = i_req_valid && (state_q != ST_DEAD);
  assign w_strobe   = (pre_q == C_PRE_LAST);
  // Heal sum is one bit wider so large amounts clamp instead of wrapping.
  assign w_heal_sum = {1'b0, actual_q} + {1'b0, i_req_amt};
  assign w_heal_hp  = (w_heal_sum > {1'b0, C_MAX_HP}) ? C_MAX_HP : w_heal_sum[15:0];
  assign w_dmg_hp   = (actual_q > i_req_amt) ? (actual_q - i_req_amt) : 16'd0;

  always_comb begin
    state_d  = state_q;
    actual_d = actual_q;
    remain_d = remain_q;
    inv_d    = inv_q;
    hit_d    = 1'b0;
    pre_d    = w_strobe ? '0 : pre_q + PRE_W'(1);

    case (state_q)
      ST_ALIVE: begin
        if (w_accept && !i_req_heal && (i_req_amt != 16'd0)) begin
          actual_d = w_dmg_hp;
          hit_d    = 1'b1;
          if (w_dmg_hp == 16'd0) begin
            state_d = ST_DEAD;
          end else if (INV_TICKS > 0) begin
            state_d = ST_INVULN;
            inv_d   = C_INV_LOAD;
          end
        end
      end
      ST_INVULN: begin
        if (i_frame_tick) begin
          inv_d = inv_q - INV_W'(1);
          if (inv_q == INV_W'(1)) begin
            state_d = ST_ALIVE;
          end
        end
      end
      default: ;
    endcase

    if (w_accept && i_req_heal) begin
      actual_d = w_heal_hp;
    end

    // Refill is instant; draining only ever moves the display down toward truth.
    if (actual_d > remain_q) begin
      remain_d = actual_d;
    end else if (w_strobe && (remain_q > actual_d)) begin
      remain_d = remain_q - 16'd1;
    end

    dead_d = (state_d == ST_DEAD) && (remain_d == 16'd0);

    if (i_restart) begin
      state_d  = ST_ALIVE;
      actual_d = C_MAX_HP;
      remain_d = C_MAX_HP;
      inv_d    = '0;
      pre_d    = '0;
      hit_d    = 1'b0;
      dead_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_ALIVE;
      actual_q <= C_MAX_HP;
      remain_q <= C_MAX_HP;
      inv_q    <= '0;
      pre_q    <= '0;
      hit_q    <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      actual_q <= actual_d;
      remain_q <= remain_d;
      inv_q    <= inv_d;
      pre_q    <= pre_d;
      hit_q    <= hit_d;
      dead_q   <= dead_d;
    end
  end

  assign o_req_ready = (state_q != ST_DEAD);
  assign o_total_hp  = C_MAX_HP;
  assign o_remain_hp = remain_q;
  assign o_actual_hp = actual_q;
  assign o_invuln    = (state_q == ST_INVULN);
  assign o_hit_pulse = hit_q;
  assign o_dead      = dead_q;

endmodule

`default_nettype wire

// File: tb/tb_hp_manager.sv
// ============================================================================
// tb_hp_manager : scoreboard bench for hp_manager (MAX_HP=20, INV_TICKS=3,
//                 DRAIN_DIV=4) with directed damage/heal/tick sequences.
// Revision      : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hp_manager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        tick = 1'b0;
  logic        valid = 1'b0;
  logic        heal = 1'b0;
  logic [15:0] amt = 16'd0;
  logic        ready;
  logic [15:0] total_hp, remain_hp, actual_hp;
  logic        invuln, hit, dead;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int exp_act[$];
  int exp_rem[$];
  int exp_hit[$];

  hp_manager #(.MAX_HP(20), .INV_TICKS(3), .DRAIN_DIV(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_restart   (restart),
    .i_frame_tick(tick),
    .i_req_valid (valid),
    .i_req_heal  (heal),
    .i_req_amt   (amt),
    .o_req_ready (ready),
    .o_total_hp  (total_hp),
    .o_remain_hp (remain_hp),
    .o_actual_hp (actual_hp),
    .o_invuln    (invuln),
    .o_hit_pulse (hit),
    .o_dead      (dead)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic send(input logic h, input logic [15:0] a);
    @(posedge clk); #1;
    valid = 1'b1; heal = h; amt = a;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic frame_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  // Monitor: every change of actual/remain HP and every hit pulse is matched
  // against the next expected entry pushed by the stimulus.
  initial begin
    logic [15:0] pa, pr;
    int last_dec;
    pa = 16'd20; pr = 16'd20; last_dec = -1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (actual_hp !== pa) begin
          if (exp_act.size() == 0) chk("actual_unexpected_change", actual_hp, pa);
          else chk("actual_seq", actual_hp, exp_act.pop_front());
          pa = actual_hp;
        end
        if (remain_hp !== pr) begin
          if (exp_rem.size() == 0) chk("remain_unexpected_change", remain_hp, pr);
          else chk("remain_seq", remain_hp, exp_rem.pop_front());
          if (int'(remain_hp) + 1 == int'(pr)) begin
            if (last_dec >= 0) chk("drain_period_mod4", (cyc - last_dec) % 4, 0);
            last_dec = cyc;
          end else begin
            last_dec = -1;
          end
          pr = remain_hp;
        end
        if (hit === 1'b1) begin
          if (exp_hit.size() == 0) chk("hit_unexpected", hit, 0);
          else chk("hit_actual", actual_hp, exp_hit.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 mon_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_actual", actual_hp, 20);
    chk("rst_remain", remain_hp, 20);
    chk("rst_ready", ready, 1);
    chk("rst_dead", dead, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_total", total_hp, 20);

    // Damage 5 in ALIVE
    exp_act.push_back(15); exp_hit.push_back(15);
    for (int v = 19; v >= 15; v--) exp_rem.push_back(v);
    send(1'b0, 16'd5);
    @(negedge clk);
    chk("dmg5_actual", actual_hp, 15);
    chk("dmg5_hit", hit, 1);
    chk("dmg5_invuln", invuln, 1);
    @(negedge clk);
    chk("dmg5_hit_once", hit, 0);

    // Damage during INVULN is discarded
    send(1'b0, 16'd7);
    @(negedge clk);
    chk("inv_dmg_actual", actual_hp, 15);
    chk("inv_dmg_hit", hit, 0);
    chk("inv_dmg_invuln", invuln, 1);
    repeat (30) @(negedge clk);
    chk("drain_done_15", remain_hp, 15);

    frame_tick(); frame_tick();
    @(negedge clk);
    chk("inv_after2", invuln, 1);
    frame_tick();
    @(negedge clk);
    chk("inv_after3", invuln, 0);

    // Heal clamps and refills instantly
    exp_act.push_back(20); exp_rem.push_back(20);
    send(1'b1, 16'd30);
    @(negedge clk);
    chk("heal_actual", actual_hp, 20);
    chk("heal_remain", remain_hp, 20);

    // Lethal damage
    exp_act.push_back(0); exp_hit.push_back(0);
    for (int v = 19; v >= 0; v--) exp_rem.push_back(v);
    send(1'b0, 16'hFFFF);
    @(negedge clk);
    chk("kill_actual", actual_hp, 0);
    chk("kill_ready", ready, 0);
    for (int i = 0; i < 120; i++) begin
      if (remain_hp == 16'd0) break;
      chk("dead_early", dead, 0);
      @(negedge clk);
    end
    chk("drain_to_zero", remain_hp, 0);
    chk("dead_at_zero", dead, 1);

    // Requests stall in DEAD
    @(posedge clk); #1 valid = 1'b1; heal = 1'b1; amt = 16'd5;
    repeat (5) begin
      @(negedge clk);
      chk("dead_ready", ready, 0);
    end
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    chk("dead_actual_held", actual_hp, 0);
    chk("dead_held", dead, 1);

    // Restart
    exp_act.push_back(20); exp_rem.push_back(20);
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    @(negedge clk);
    chk("rs_actual", actual_hp, 20);
    chk("rs_remain", remain_hp, 20);
    chk("rs_ready", ready, 1);
    chk("rs_dead", dead, 0);
    chk("rs_invuln", invuln, 0);
    send(1'b0, 16'd0);
    @(negedge clk);
    chk("dmg0_hit", hit, 0);
    chk("dmg0_invuln", invuln, 0);
    chk("dmg0_actual", actual_hp, 20);

    // Async reset mid-drain
    exp_act.push_back(12); exp_hit.push_back(12);
    exp_rem.push_back(19); exp_rem.push_back(18); exp_rem.push_back(17);
    exp_rem.push_back(20); exp_act.push_back(20);
    send(1'b0, 16'd8);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (remain_hp == 16'd17) break;
    end
    chk("mid_remain17", remain_hp, 17);
    chk("mid_actual12", actual_hp, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_remain", remain_hp, 20);
    chk("arst_actual", actual_hp, 20);
    chk("arst_invuln", invuln, 0);
    chk("arst_ready", ready, 1);
    @(negedge clk); #2 rst_n = 1'b1;

    // Damage together with the last invulnerability tick
    exp_act.push_back(18); exp_hit.push_back(18);
    exp_rem.push_back(19); exp_rem.push_back(18);
    send(1'b0, 16'd2);
    frame_tick(); frame_tick();
    @(posedge clk); #1 tick = 1'b1; valid = 1'b1; heal = 1'b0; amt = 16'd5;
    @(posedge clk); #1 tick = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("lasttick_invuln", invuln, 0);
    chk("lasttick_actual", actual_hp, 18);
    chk("lasttick_hit", hit, 0);
    exp_act.push_back(17); exp_hit.push_back(17); exp_rem.push_back(17);
    send(1'b0, 16'd1);
    @(negedge clk);
    chk("alive_again_hit", hit, 1);
    chk("alive_again_invuln", invuln, 1);

    repeat (40) @(negedge clk);
    chk("q_act_empty", exp_act.size(), 0);
    chk("q_rem_empty", exp_rem.size(), 0);
    chk("q_hit_empty", exp_hit.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
